// File: rtl/matmul_pkg.sv
// matmul_pkg: shared field encodings and word-size default for the matmul datapath.
package matmul_pkg;
    localparam int DEFAULT_WORD_SIZE = 16;
    typedef enum logic [1:0] {
        FIELD_VALUE = 2'd0,
        FIELD_STEP  = 2'd1,
        FIELD_LIMIT = 2'd2,
        FIELD_NONE  = 2'd3
    } field_e;
endpackage

// File: rtl/index_channel.sv
// index_channel: one loop-index channel (value/step/limit registers, adder, limit compare).
// wrap is combinational so the parent can chain carries within one edge.
module index_channel
    import matmul_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int DEFAULT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_field,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 clr,
    input  logic                 carry_in,
    output logic                 wrap,
    output logic [WORD_SIZE-1:0] value
);
    logic [WORD_SIZE-1:0] r_value, r_step, r_limit;
    logic [WORD_SIZE:0]   w_sum;
    assign w_sum = {1'b0, r_value} + {1'b0, r_step};
    // a written or cleared channel neither advances nor passes a carry on
    assign wrap  = carry_in & ~wr_en & ~clr & (r_step != '0) & (w_sum > {1'b0, r_limit});
    assign value = r_value;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_step  <= WORD_SIZE'(DEFAULT_STEP);
            r_limit <= '1;
        end else if (wr_en) begin
            if (wr_field == FIELD_VALUE) r_value <= data_in;
            if (wr_field == FIELD_STEP)  r_step  <= data_in;
            if (wr_field == FIELD_LIMIT) r_limit <= data_in;
        end else if (clr) begin
            r_value <= '0;
        end else if (carry_in) begin
            r_value <= wrap ? '0 : w_sum[WORD_SIZE-1:0];
        end
    end
endmodule

// File: rtl/loop_index_bank.sv
// loop_index_bank: bank of loop-index channels, advanced independently or as a nested-loop
// counter with channel 0 innermost; registers per-channel wrap pulses and a sticky done.
module loop_index_bank
    import matmul_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int CHANNELS     = 3,
    parameter int DEFAULT_STEP = 1,
    localparam int SW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [SW-1:0]                 wr_sel,
    input  logic [1:0]                    wr_field,
    input  logic [WORD_SIZE-1:0]          data_in,
    input  logic                          inc,
    input  logic                          cascade,
    input  logic [CHANNELS-1:0]           inc_mask,
    input  logic                          clr,
    output logic [CHANNELS*WORD_SIZE-1:0] data_out,
    output logic [CHANNELS-1:0]           wrap,
    output logic                          done
);
    logic [CHANNELS-1:0] w_wrap, w_adv, w_wr, r_wrap;
    logic                w_inc, r_done;
    assign w_inc = inc & ~clr;
    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            if (c == 0) begin : g_first
                assign w_adv[c] = w_inc & (cascade | inc_mask[c]);
            end else begin : g_rest
                assign w_adv[c] = cascade ? w_wrap[c-1] : w_inc & inc_mask[c];
            end
            assign w_wr[c] = wr_en & (wr_sel == SW'(c)) & (wr_field != FIELD_NONE);
            index_channel #(
                .WORD_SIZE    (WORD_SIZE),
                .DEFAULT_STEP (DEFAULT_STEP)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (w_wr[c]),
                .wr_field (wr_field),
                .data_in  (data_in),
                .clr      (clr),
                .carry_in (w_adv[c]),
                .wrap     (w_wrap[c]),
                .value    (data_out[c*WORD_SIZE +: WORD_SIZE])
            );
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= '0;
            r_done <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
            if (clr || (wr_en && wr_field == FIELD_VALUE)) r_done <= 1'b0;
            else if (cascade && w_wrap[CHANNELS-1])        r_done <= 1'b1;
        end
    end
    assign wrap = r_wrap;
    assign done = r_done;
endmodule

// File: tb/tb_loop_index_bank.sv
// tb_loop_index_bank: directed test-plan scenarios plus random traffic against a behavioural model.
module tb_loop_index_bank;
    localparam int W = 16;
    localparam int C = 3;
    logic           clk = 1'b0;
    logic           rst, wr_en, inc, cascade, clr, done;
    logic [1:0]     wr_sel, wr_field;
    logic [W-1:0]   data_in;
    logic [C-1:0]   inc_mask, wrap;
    logic [C*W-1:0] data_out;
    int             n_checks = 0;
    int             n_fail = 0;
    int             m_val[C], m_step[C], m_lim[C];
    logic [C-1:0]   m_wrap;
    logic           m_done;
    always #5 clk = ~clk;
    loop_index_bank #(.WORD_SIZE(W), .CHANNELS(C), .DEFAULT_STEP(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_field(wr_field),
        .data_in(data_in), .inc(inc), .cascade(cascade), .inc_mask(inc_mask), .clr(clr),
        .data_out(data_out), .wrap(wrap), .done(done)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // next state from the behavioural rules, using this cycle's inputs
    function automatic void model();
        logic [C-1:0] nw;
        logic carry, adv, wr;
        if (rst) begin
            for (int c = 0; c < C; c++) begin
                m_val[c] = 0; m_step[c] = 1; m_lim[c] = 'hFFFF;
            end
            m_wrap = '0;
            m_done = 1'b0;
            return;
        end
        nw = '0;
        carry = inc && !clr;
        for (int c = 0; c < C; c++) begin
            adv = cascade ? carry : (inc && !clr && inc_mask[c]);
            wr  = wr_en && (int'(wr_sel) == c) && (wr_field != 2'd3);
            if (wr) begin
                if (wr_field == 2'd0) m_val[c] = int'(data_in);
                if (wr_field == 2'd1) m_step[c] = int'(data_in);
                if (wr_field == 2'd2) m_lim[c] = int'(data_in);
            end else if (clr) begin
                m_val[c] = 0;
            end else if (adv && m_step[c] != 0) begin
                if (m_val[c] + m_step[c] > m_lim[c]) begin
                    m_val[c] = 0;
                    nw[c] = 1'b1;
                end else begin
                    m_val[c] = m_val[c] + m_step[c];
                end
            end
            carry = nw[c];
        end
        m_wrap = nw;
        if (clr || (wr_en && wr_field == 2'd0)) m_done = 1'b0;
        else if (cascade && nw[C-1])            m_done = 1'b1;
    endfunction
    task automatic tick();
        @(posedge clk);
        model();
        #1;
        for (int c = 0; c < C; c++) check("model_val", 64'(data_out[c*W +: W]), 64'(m_val[c]));
        check("model_wrap", 64'(wrap), 64'(m_wrap));
        check("model_done", 64'(done), 64'(m_done));
    endtask
    task automatic idle();
        rst = 0; wr_en = 0; inc = 0; clr = 0; cascade = 0; inc_mask = '0;
        wr_sel = '0; wr_field = 2'd3; data_in = '0;
    endtask
    task automatic write(input int sel, input int field, input int data);
        idle();
        wr_en = 1; wr_sel = 2'(sel); wr_field = 2'(field); data_in = W'(data);
        tick();
        idle();
    endtask
    task automatic do_reset();
        idle(); rst = 1; tick(); idle();
    endtask
    initial begin
        int exp_v[4];
        int exp_w[4];
        exp_v = '{2, 4, 0, 2};
        exp_w = '{0, 0, 1, 0};
        do_reset();
        // reset mid-count with a concurrent step write
        for (int i = 0; i < 5; i++) begin idle(); inc = 1; cascade = 1; tick(); end
        idle(); rst = 1; wr_en = 1; wr_sel = 0; wr_field = 2'd1; data_in = 16'd5; inc = 1; tick();
        check("rst_vals", 64'(data_out), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        idle(); inc = 1; cascade = 1; tick();
        check("rst_step1", 64'(data_out[W-1:0]), 64'd1);
        // independent mode, ch1 limit 5 step 2
        do_reset();
        write(1, 2, 5);
        write(1, 1, 2);
        for (int i = 0; i < 4; i++) begin
            idle(); inc = 1; inc_mask = 3'b010; tick();
            check("ind_ch1", 64'(data_out[2*W-1:W]), 64'(exp_v[i]));
            check("ind_wrap", 64'(wrap), exp_w[i] ? 64'd2 : 64'd0);
            check("ind_ch0_ch2", 64'({data_out[3*W-1:2*W], data_out[W-1:0]}), 64'd0);
        end
        // cascade nest 2x3x2
        do_reset();
        write(0, 2, 1);
        write(1, 2, 2);
        write(2, 2, 1);
        for (int i = 1; i <= 12; i++) begin
            idle(); inc = 1; cascade = 1; tick();
            if (i == 11) begin
                check("casc11_vals", 64'(data_out), {16'd0, 16'd1, 16'd2, 16'd1});
                check("casc11_done", 64'(done), 64'd0);
            end
        end
        check("casc12_vals", 64'(data_out), 64'd0);
        check("casc12_wrap", 64'(wrap), 64'd7);
        check("casc12_done", 64'(done), 64'd1);
        // clr with inc while done is set
        idle(); clr = 1; inc = 1; cascade = 1; tick();
        check("clr_vals", 64'(data_out), 64'd0);
        check("clr_wrap", 64'(wrap), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        idle(); inc = 1; cascade = 1; tick();
        check("clr_step_kept", 64'(data_out[W-1:0]), 64'd1);
        // carry-out counts as exceeding the limit
        do_reset();
        write(0, 0, 'hFFFE);
        write(0, 1, 3);
        idle(); inc = 1; inc_mask = 3'b001; tick();
        check("ovf_val", 64'(data_out[W-1:0]), 64'd0);
        check("ovf_wrap", 64'(wrap), 64'd1);
        // write to ch0 at its limit while cascading
        do_reset();
        write(0, 2, 1);
        idle(); inc = 1; cascade = 1; tick();
        check("wrinc_pre", 64'(data_out[W-1:0]), 64'd1);
        idle(); inc = 1; cascade = 1; wr_en = 1; wr_sel = 0; wr_field = 2'd0; data_in = 16'd7; tick();
        check("wrinc_ch0", 64'(data_out[W-1:0]), 64'd7);
        check("wrinc_ch1", 64'(data_out[2*W-1:W]), 64'd0);
        check("wrinc_wrap", 64'(wrap), 64'd0);
        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            idle();
            rst      = ($urandom_range(63) == 0);
            clr      = ($urandom_range(31) == 0);
            inc      = ($urandom_range(3) != 0);
            cascade  = ($urandom_range(1) == 1);
            inc_mask = C'($urandom);
            if ($urandom_range(3) == 0) begin
                wr_en    = 1;
                wr_sel   = 2'($urandom_range(3));
                wr_field = 2'($urandom_range(3));
                data_in  = ($urandom_range(15) == 0) ? W'($urandom) :
                           (wr_field == 2'd1) ? W'($urandom_range(3)) : W'($urandom_range(9));
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
